// File: rtl/gon_pkg.sv
// Shared constants and types for the global output network X-bus collector.
package gon_pkg;

  localparam int GON_DATA_WIDTH    = 64;
  localparam int GON_COL_TAG_WIDTH = 4;
  localparam int GON_NUM_OF_COLS   = 14;

  typedef logic [GON_COL_TAG_WIDTH-1:0] col_tag_t;

endpackage

// File: rtl/gon_col_id.sv
// Per-column scan-loaded ID register and tag compare.
// The ID shifts right one bit per clock while se_id_i is high; so_id_o feeds the next column.
module gon_col_id
  import gon_pkg::*;
#(
  parameter int W = GON_COL_TAG_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         se_id_i,
  input  logic         scan_in_i,
  input  logic [W-1:0] col_tag_i,
  input  logic         tag_valid_i,
  input  logic         enable_i,
  output logic         so_id_o,
  output logic         match_o
);

  logic [W-1:0] id_q;
  logic [W-1:0] id_d;

  assign id_d = se_id_i ? {scan_in_i, id_q[W-1:1]} : id_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) id_q <= '0;
    else        id_q <= id_d;
  end

  assign so_id_o = id_q[0];
  assign match_o = tag_valid_i && (id_q == col_tag_i) && enable_i;

endmodule

// File: rtl/gon_xbus.sv
// Collects psum words from the tag-matching PE columns into a one-entry output register (1-cycle latency);
// ready_out drops for every column under GLB back-pressure or ID scan. GON_RR_ARB_EN selects round-robin arbitration.
module gon_xbus
  import gon_pkg::*;
#(
  parameter int DATA_WIDTH    = GON_DATA_WIDTH,
  parameter int COL_TAG_WIDTH = GON_COL_TAG_WIDTH,
  parameter int NUM_OF_COLS   = GON_NUM_OF_COLS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    data_in [0:NUM_OF_COLS-1],
  input  logic [0:NUM_OF_COLS-1]   enable_in,
  output logic [0:NUM_OF_COLS-1]   ready_out,
  input  logic [COL_TAG_WIDTH-1:0] col_tag,
  input  logic                     tag_valid,
  input  logic                     ready_in,
  output logic                     enable_out,
  output logic [DATA_WIDTH-1:0]    data_out,
  input  logic                     se_id,
  input  logic                     si_id,
  output logic                     so_id
);

  localparam int IDX_W = (NUM_OF_COLS > 1) ? $clog2(NUM_OF_COLS) : 1;

  logic [NUM_OF_COLS:0]   scan_chain;
  logic [NUM_OF_COLS-1:0] match;
  logic                   gnt_vld;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   can_load;
  logic                   xfer;
  logic                   out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;

  assign scan_chain[0] = si_id;
  assign so_id         = scan_chain[NUM_OF_COLS];

  for (genvar i = 0; i < NUM_OF_COLS; i++) begin : g_col
    gon_col_id #(.W(COL_TAG_WIDTH)) u_col_id (
      .clk         (clk),
      .reset       (reset),
      .se_id_i     (se_id),
      .scan_in_i   (scan_chain[i]),
      .col_tag_i   (col_tag),
      .tag_valid_i (tag_valid),
      .enable_i    (enable_in[i]),
      .so_id_o     (scan_chain[i+1]),
      .match_o     (match[i])
    );
  end

`ifdef GON_RR_ARB_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_OF_COLS) sum -= NUM_OF_COLS;
    return IDX_W'(sum);
  endfunction

  // Scan downwards so the match closest to the pointer is the last (winning) assignment.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int off = NUM_OF_COLS-1; off >= 0; off--) begin
      if (match[wrap_add(ptr_q, off)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap_add(ptr_q, off);
      end
    end
  end

  assign ptr_d = xfer ? wrap_add(gnt_idx, 1) : ptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_OF_COLS-1; i >= 0; i--) begin
      if (match[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end
`endif

  assign can_load = !out_vld_q || ready_in;
  assign xfer     = gnt_vld && can_load && !se_id;

  // Gated by reset so no column sees an accept while the collector is held in reset.
  always_comb begin
    ready_out = '0;
    if (xfer && reset) ready_out[gnt_idx] = 1'b1;
  end

  assign out_vld_d = xfer || (out_vld_q && !ready_in);
  assign data_d    = xfer ? data_in[gnt_idx] : data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vld_q <= 1'b0;
      data_q    <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      data_q    <= data_d;
    end
  end

  assign enable_out = out_vld_q;
  assign data_out   = data_q;

endmodule

// File: tb/tb_gon_xbus.sv
// Scoreboard bench for gon_xbus: expected words queued at handshake, compared when enable_out shows them.
module tb_gon_xbus;
  import gon_pkg::*;

  localparam int NC = GON_NUM_OF_COLS;
  typedef col_tag_t idarr_t [NC];

  logic            clk;
  logic            reset;
  logic [63:0]     data_in [0:NC-1];
  logic [0:NC-1]   enable_in;
  logic [0:NC-1]   ready_out;
  logic [3:0]      col_tag;
  logic            tag_valid;
  logic            ready_in;
  logic            enable_out;
  logic [63:0]     data_out;
  logic            se_id;
  logic            si_id;
  logic            so_id;

  gon_xbus u_dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .enable_in  (enable_in),
    .ready_out  (ready_out),
    .col_tag    (col_tag),
    .tag_valid  (tag_valid),
    .ready_in   (ready_in),
    .enable_out (enable_out),
    .data_out   (data_out),
    .se_id      (se_id),
    .si_id      (si_id),
    .so_id      (so_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          dseq  = 0;
  logic [63:0] exp_q [$];
  bit          sc_q  [$];
  int          glog  [$];
  bit          m_vld;
  logic [63:0] m_last;
  int          m_ptr;
  idarr_t      mid;
  idarr_t      ids_a;
  idarr_t      ids_mm;
  int          mm_exp [6];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nd();
    dseq++;
    for (int i = 0; i < NC; i++) data_in[i] = {dseq[31:0], 32'(i)};
  endtask

  function automatic int pick();
    int i;
    if (!tag_valid) return -1;
`ifdef GON_RR_ARB_EN
    for (int off = 0; off < NC; off++) begin
      i = (m_ptr + off) % NC;
      if (enable_in[i] && mid[i] == col_tag) return i;
    end
`else
    for (int k = 0; k < NC; k++) begin
      i = k;
      if (enable_in[i] && mid[i] == col_tag) return i;
    end
`endif
    return -1;
  endfunction

  task automatic cyc();
    logic [0:NC-1] er;
    int g;
    bit can, ld, dr;
    @(negedge clk);
    can = !m_vld || ready_in;
    g   = pick();
    ld  = (g >= 0) && can && !se_id;
    er  = '0;
    if (ld) er[g] = 1'b1;
    chk("rdy", 64'(ready_out), 64'(er));
    if (se_id) chk("so_echo", 64'(so_id), 64'(sc_q.pop_front()));
    dr = m_vld && ready_in;
    @(posedge clk);
    if (dr && exp_q.size() > 0) void'(exp_q.pop_front());
    if (ld) begin
      exp_q.push_back(data_in[g]);
      m_last = data_in[g];
      glog.push_back(g);
      m_ptr = (g + 1) % NC;
    end
    m_vld = ld || (m_vld && !ready_in);
    #1;
    chk("vld", 64'(enable_out), 64'(m_vld));
    if (m_vld && exp_q.size() > 0) chk("dat", data_out, exp_q[0]);
    else                           chk("hold", data_out, m_last);
  endtask

  // so_id must replay the previous chain contents, last column LSB first.
  task automatic load_ids(input idarr_t ids, input int rin_from);
    int k;
    sc_q.delete();
    for (int c = NC-1; c >= 0; c--)
      for (int b = 0; b < 4; b++) sc_q.push_back(mid[c][b]);
    se_id = 1'b1;
    k = 0;
    for (int c = NC-1; c >= 0; c--) begin
      for (int b = 0; b < 4; b++) begin
        si_id    = ids[c][b];
        ready_in = (k >= rin_from);
        nd();
        cyc();
        k++;
      end
    end
    se_id = 1'b0;
    si_id = 1'b0;
    mid   = ids;
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_last = '0;
    m_ptr  = 0;
    exp_q.delete();
    for (int i = 0; i < NC; i++) mid[i] = '0;
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      ids_a[i]  = col_tag_t'(i);
      ids_mm[i] = col_tag_t'(i);
    end
    ids_mm[2] = 4'd4; ids_mm[7] = 4'd4; ids_mm[9] = 4'd4; ids_mm[4] = 4'd15;
`ifdef GON_RR_ARB_EN
    mm_exp = '{2, 7, 9, 2, 7, 9};
`else
    mm_exp = '{2, 2, 2, 2, 2, 2};
`endif
    model_reset();

    reset = 1'b1; se_id = 1'b0; si_id = 1'b0; ready_in = 1'b0;
    col_tag = 4'd0; tag_valid = 1'b1; enable_in = '1;
    nd();
    #1 reset = 1'b0;
    #12;
    chk("rst_rdy", 64'(ready_out), 64'd0);
    chk("rst_vld", 64'(enable_out), 64'd0);
    chk("rst_dat", data_out, 64'd0);
    chk("rst_so",  64'(so_id), 64'd0);
    tag_valid = 1'b0; enable_in = '0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Load IDs col i = i twice; the second pass echoes the first.
    load_ids(ids_a, 0);
    load_ids(ids_a, 0);

    tag_valid = 1'b1; col_tag = 4'd5; enable_in = '1; ready_in = 1'b1;
    nd(); cyc();

    col_tag = 4'd3; enable_in = '0; enable_in[3] = 1'b1;
    nd(); data_in[3] = 64'hA5; cyc();
    chk("a5_dat", data_out, 64'hA5);
    chk("a5_vld", 64'(enable_out), 64'd1);

    ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin nd(); cyc(); end
    ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin nd(); cyc(); end

    enable_in = '1;
    col_tag = 4'd6; nd(); cyc();
    col_tag = 4'd8; nd(); cyc();
    tag_valid = 1'b0; nd(); cyc();
    tag_valid = 1'b1; col_tag = 4'd15; nd(); cyc();
    nd(); cyc();

    // Async reset with a held word.
    col_tag = 4'd3; enable_in = '0; enable_in[3] = 1'b1; ready_in = 1'b0;
    nd(); cyc();
    #2;
    reset = 1'b0; col_tag = 4'd0; enable_in = '1;
    #1;
    chk("arst_rdy", 64'(ready_out), 64'd0);
    chk("arst_vld", 64'(enable_out), 64'd0);
    chk("arst_dat", data_out, 64'd0);
    model_reset();
    tag_valid = 1'b0; enable_in = '0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    load_ids(ids_mm, 0);
    tag_valid = 1'b1; col_tag = 4'd4; ready_in = 1'b1;
    enable_in = '0; enable_in[2] = 1'b1; enable_in[7] = 1'b1; enable_in[9] = 1'b1;
    glog.delete();
    for (int k = 0; k < 6; k++) begin nd(); cyc(); end
    chk("mm_cnt", 64'(glog.size()), 64'd6);
    for (int k = 0; k < 6; k++)
      if (k < glog.size()) chk("mm_gnt", 64'(glog[k]), 64'(mm_exp[k]));

    // Scan while a word is held: it drains once ready_in returns, nothing new is captured.
    ready_in = 1'b0;
    nd(); cyc();
    load_ids(ids_mm, 3);
    ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin nd(); cyc(); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gon_xbus.md
Name: gon_xbus

Overview:
- Global Output Network X-bus collector: the return path from the PE-array columns to the global buffer (GLB).
- Takes psum words from NUM_OF_COLS column ports and forwards one per cycle onto a single GLB-bound bus.
- Only columns whose scan-programmed ID matches the GLB-issued col_tag may send.
- Per-column ID registers sit on the same se_id/si_id/so_id scan chain as the input network; the output is a one-entry registered stage.

Parameters:
- DATA_WIDTH, 64, psum word width.
- COL_TAG_WIDTH, 4, width of the column ID and tag.
- NUM_OF_COLS, 14, number of column ports.

Ports:
- clk  input  1  clock; all state on posedge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH x NUM_OF_COLS  unpacked [0:NUM_OF_COLS-1]; per-column psum.
- enable_in  input  [0:NUM_OF_COLS-1]  per-column valid.
- ready_out  output  [0:NUM_OF_COLS-1]  per-column accept; a transfer occurs when enable_in[i] and ready_out[i] are both high.
- col_tag  input  COL_TAG_WIDTH  column ID the GLB is collecting from.
- tag_valid  input  1  col_tag is meaningful.
- ready_in  input  1  GLB can accept data_out.
- enable_out  output  1  data_out valid.
- data_out  output  DATA_WIDTH  psum to GLB.
- se_id, si_id  input  1  ID scan enable and scan in.
- so_id  output  1  ID scan out.

Behaviour:
- Reset (reset=0, async):
  - All ID regs = 0; out_valid = 0; data_out = 0; enable_out = 0; ready_out = 0; round-robin pointer = 0.
- ID scan (se_id=1):
  - Each posedge, col i ID <= {scan_in_i, id_i[W-1:1]}.
  - scan_in_0 = si_id; scan_in_{i+1} = id_i[0]; so_id = id_{N-1}[0] (combinational from the register).
  - Full reload takes NUM_OF_COLS*COL_TAG_WIDTH cycles.
  - While se_id=1: all ready_out=0 and no new capture; an already-held output word stays and may still drain via ready_in.
- Match: match[i] = tag_valid && (id_i == col_tag) && enable_in[i]. Several columns may match.
- Arbitration: a single grant one-hot, gnt, is chosen from match each cycle (see Optional Feature).
- Flow:
  - can_load = !out_valid || ready_in.
  - ready_out[i] = gnt[i] && can_load && !se_id. At most one bit is ever high.
  - On a transfer: data_out <= data_in[gnt], out_valid <= 1 next cycle. Latency is 1 cycle from handshake to enable_out.
  - If out_valid && ready_in with no new transfer: out_valid <= 0. data_out holds its last value.
  - Simultaneous drain and load: the register is replaced and out_valid stays 1 (full throughput, one word/cycle).
  - enable_out = out_valid. Back-pressure (ready_in=0 with out_valid=1) gives ready_out=0 to all columns.
- Edge cases:
  - tag_valid=0 or no match: no grant, ready_out=0.
  - Tag change mid-stream takes effect the same cycle.
  - Reset mid-transfer drops the held word.

Optional Feature:
- Macro GON_RR_ARB_EN.
- Defined: round-robin among matches.
  - Search starts at the pointer; on a transfer, pointer <= grant index+1, wrapping to 0 after NUM_OF_COLS-1.
  - Pointer holds otherwise.
- Undefined: fixed priority, lowest matching index wins; no pointer register.

Decomposition:
- Package gon_pkg:
  - default constants GON_DATA_WIDTH=64, GON_COL_TAG_WIDTH=4, GON_NUM_OF_COLS=14;
  - typedef col_tag_t (logic [COL_TAG_WIDTH-1:0]).
- Sub-module gon_col_id: one per column, generated. Contains the ID shift register, scan in/out and the tag compare; outputs so_id and the match flag.
- Arbiter and output register live in the top.

Test Plan:
- Scan: shift 56 bits over 56 cycles with se_id=1, loading IDs 0..13 (col i=i) -> so_id echoes bits from 56 cycles earlier; with tag 5, only col 5 sees ready_out.
- Single column: tag_valid=1, col_tag=3, enable_in[3]=1, data 0xA5, ready_in=1 -> ready_out[3]=1 the same cycle; enable_out=1, data_out=0xA5 the next cycle.
- Back-pressure: out_valid=1, ready_in=0 -> all ready_out=0 and data_out held; ready_in back to 1 -> drains, then the next word loads with no bubble.
- Multi-match:
  - Cols 2, 7, 9 all ID 4, all enabled, tag 4, ready_in=1.
  - RR: grants 2, 7, 9, 2...
  - Fixed: 2 every cycle.
- Scan during traffic: se_id=1 while a word is held -> ready_out=0, held word drains, no capture.
- Async reset mid-stream -> enable_out=0, data_out=0 and ready_out=0 immediately, before the next clk edge.
